ntt_twiddle_gen: RTL and testbench
==================================

// Module: ntt_twiddle_gen
// PURPOSE
//  Upstream twiddle source for the KDSP modular multiplier in the ML-KEM NTT datapath (q=3329).
//  After reset it self-builds a 128-entry table zeta[k] = 17^brv7(k) mod q, storing entry k at address k.
//  On each start it streams zeta[1..127] over a valid/ready channel into the multiplier's b operand.
// PARAMETERS
//  Q_MOD    3329  modulus q (12-bit; must match KDSP)
//  ZETA_ROOT  17  primitive 256th root of unity mod q
//  N_TW      128  table depth; the address width is log2(N_TW)=7
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   1-cycle pulse; begins a stream (ignored unless state is IDLE)
//  mode_inv   in   1   sampled on start; only present with NTT_TW_INV_EN
//  tw_data    out 12   twiddle value, always < Q_MOD
//  tw_idx     out  7   k of the current tw_data
//  tw_valid   out  1   tw_data/tw_idx valid
//  tw_ready   in   1   consumer accepts when tw_valid & tw_ready
//  tw_last    out  1   high with the final beat of a stream
//  busy       out  1   high in INIT or STREAM
//  init_done  out  1   table built; stays high until the next reset
// BEHAVIOUR
//  Reset values: all outputs 0; table contents undefined; FSM = INIT; power accumulator p=1; counter i=0.
//  Reset mid-operation: the stream aborts immediately; INIT reruns from i=0.
//  FSM INIT:
//   - Each cycle: write p to table[brv7(i)], then p <= (p*ZETA_ROOT) mod Q_MOD.
//   - The product is 12x5 -> 17 bits. Reduce it in a single cycle; quotient <= 16.
//   - After i=127 is written, go to IDLE and set init_done.
//   - INIT takes exactly 128 cycles after rst_n deasserts.
//  FSM IDLE: busy=0. On start, go to STREAM with k=1 (or k=127 for inverse).
//  FSM STREAM:
//   - 1-cycle synchronous table read feeds a 2-entry output skid.
//   - The first tw_valid rises 2 cycles after the start edge.
//   - With tw_ready held high, the channel sustains 1 beat/cycle: 127 beats in 127 consecutive cycles.
//   - While tw_valid=1 and tw_ready=0, tw_data, tw_idx and tw_last hold stable. No beat is lost or duplicated.
//   - tw_last is asserted on k=127 (forward) or k=1 (inverse). After that beat is accepted, go to IDLE.
//  start while busy, or before init_done, is ignored and has no side effect.
//  tw_ready while tw_valid=0 is a don't-care.
// CONFIGURATION
//  NTT_TW_INV_EN defined:
//   - The mode_inv port exists.
//   - mode_inv=1 streams k=127 down to 1, with tw_data = zeta[k] unchanged. The consumer negates.
//  NTT_TW_INV_EN undefined:
//   - No mode_inv port; the stream is always forward k=1..127.
// STRUCTURE
//  Package ntt_pkg:
//   - Q_MOD, ZETA_ROOT, N_TW, the coeff_t (12-bit) typedef
//   - function brv7()
//   - state enum {INIT, IDLE, STREAM}
//  Sub-module tw_mulmod_const: combinational (p*ZETA_ROOT) mod Q_MOD; the rest stays in the top.
// TESTING
//  1. rst_n released -> init_done=1 after exactly 128 cycles; busy=1 throughout INIT.
//  2. start, tw_ready=1 -> beats (k,data):
//     - (1,1729) (2,2580) (3,3289) ... (64,17) ... (127,2154)
//     - tw_last on k=127 only; 127 beats total.
//  3. Random tw_ready stalls (~50%) -> the same 127-value sequence, no drops or repeats, outputs stable while stalled.
//  4. start during STREAM or INIT -> ignored; the ongoing sequence is unchanged.
//  5. rst_n pulsed low mid-stream (at k=40) -> outputs 0 at once; INIT reruns; the next stream starts again at k=1.
//  6. NTT_TW_INV_EN, mode_inv=1 -> first beat (127,2154), last beat (1,1729) with tw_last.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants, types and helpers for the ML-KEM twiddle generator.
package ntt_pkg;

   localparam int unsigned Q_MOD     = 3329;
   localparam int unsigned ZETA_ROOT = 17;
   localparam int unsigned N_TW      = 128;
   localparam int unsigned IDX_W     = 7;

   // Barrett constant: floor(2^20 / Q_MOD); keeps the quotient estimate within one of exact
   localparam int unsigned BARRETT_M  = 314;
   localparam int unsigned BARRETT_SH = 20;

   typedef logic [11:0]      coeff_t;
   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [1:0] {
      INIT   = 2'd0,
      IDLE   = 2'd1,
      STREAM = 2'd2
   } state_t;

   function automatic idx_t brv7(input idx_t k);
      idx_t r;
      for (int b = 0; b < IDX_W; b++) begin
         r[b] = k[IDX_W-1-b];
      end
      return r;
   endfunction

endpackage

// File: rtl/tw_mulmod_const.sv
// Combinational r = (a * ZETA_ROOT) mod Q_MOD for a < Q_MOD; one Barrett step plus one
// conditional subtract.
module tw_mulmod_const
   import ntt_pkg::*;
(
   input  coeff_t a,
   output coeff_t r
);

   logic [16:0] prod;
   logic [24:0] t;
   logic [4:0]  q_est;
   logic [12:0] r0;
   logic [12:0] r1;

   always_comb begin
      prod  = {5'd0, a} * 17'(ZETA_ROOT);
      t     = 25'(prod) * 25'(BARRETT_M);
      q_est = 5'(t >> BARRETT_SH);
      // q_est is q or q-1, so the remainder lands in [0, 2*Q_MOD)
      r0    = 13'(prod - 17'(q_est) * 17'(Q_MOD));
      r1    = r0 - 13'(Q_MOD);
      r     = (r0 >= 13'(Q_MOD)) ? coeff_t'(r1) : coeff_t'(r0);
   end

endmodule

// File: rtl/ntt_twiddle_gen.sv
// Twiddle source for the ML-KEM NTT: builds zeta[k] = 17^brv7(k) mod q after reset, then
// streams zeta[1..127] on start. Optional NTT_TW_INV_EN adds mode_inv for a k=127..1 stream.
//
// state  | meaning
// INIT   | building the table, one power of ZETA_ROOT per cycle
// IDLE   | table ready, waiting for start
// STREAM | reading the table into the 2-entry output skid
module ntt_twiddle_gen
   import ntt_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
`ifdef NTT_TW_INV_EN
   input  logic        mode_inv,
`endif
   output logic [11:0] tw_data,
   output logic [6:0]  tw_idx,
   output logic        tw_valid,
   input  logic        tw_ready,
   output logic        tw_last,
   output logic        busy,
   output logic        init_done
);

   state_t state;
   coeff_t p;
   coeff_t p_next;
   idx_t   init_i;

   coeff_t table_mem [N_TW];

   idx_t   issue_k;
   idx_t   issue_cnt;
   logic   dir_inv;
   logic   start_inv;

   coeff_t rd_data;
   idx_t   rd_idx;
   logic   rd_last;
   logic   rd_v;

   coeff_t skid_data;
   idx_t   skid_idx;
   logic   skid_last;
   logic   skid_v;

   logic       pop;
   logic [1:0] fill;
   logic       issue_en;

`ifdef NTT_TW_INV_EN
   assign start_inv = mode_inv;
`else
   assign start_inv = 1'b0;
`endif

   tw_mulmod_const u_mulmod (
      .a (p),
      .r (p_next)
   );

   assign pop  = tw_valid & tw_ready;
   // Entries held next cycle if we do not issue now: head + skid + read in flight - pop
   assign fill = 2'({1'b0, tw_valid} + {1'b0, skid_v} + {1'b0, rd_v} - {1'b0, pop});
   assign issue_en = (state == STREAM) && (issue_cnt != '0) && (fill <= 2'd1);

   always_ff @(posedge clk) begin
      if (state == INIT) begin
         table_mem[brv7(init_i)] <= p;
      end
      if (issue_en) begin
         rd_data <= table_mem[issue_k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         p         <= coeff_t'(1);
         init_i    <= '0;
         init_done <= 1'b0;
         busy      <= 1'b0;
         issue_k   <= '0;
         issue_cnt <= '0;
         dir_inv   <= 1'b0;
         rd_idx    <= '0;
         rd_last   <= 1'b0;
         rd_v      <= 1'b0;
         skid_data <= '0;
         skid_idx  <= '0;
         skid_last <= 1'b0;
         skid_v    <= 1'b0;
         tw_data   <= '0;
         tw_idx    <= '0;
         tw_last   <= 1'b0;
         tw_valid  <= 1'b0;
      end else begin
         rd_v <= issue_en;
         if (issue_en) begin
            rd_idx    <= issue_k;
            rd_last   <= (issue_cnt == idx_t'(1));
            issue_cnt <= issue_cnt - idx_t'(1);
            issue_k   <= dir_inv ? issue_k - idx_t'(1) : issue_k + idx_t'(1);
         end

         if (!tw_valid || pop) begin
            if (skid_v) begin
               tw_data  <= skid_data;
               tw_idx   <= skid_idx;
               tw_last  <= skid_last;
               tw_valid <= 1'b1;
               skid_v   <= rd_v;
               if (rd_v) begin
                  skid_data <= rd_data;
                  skid_idx  <= rd_idx;
                  skid_last <= rd_last;
               end
            end else if (rd_v) begin
               tw_data  <= rd_data;
               tw_idx   <= rd_idx;
               tw_last  <= rd_last;
               tw_valid <= 1'b1;
            end else begin
               tw_valid <= 1'b0;
            end
         end else if (rd_v) begin
            skid_data <= rd_data;
            skid_idx  <= rd_idx;
            skid_last <= rd_last;
            skid_v    <= 1'b1;
         end

         case (state)
            INIT: begin
               busy   <= 1'b1;
               p      <= p_next;
               init_i <= init_i + idx_t'(1);
               if (init_i == idx_t'(N_TW - 1)) begin
                  state     <= IDLE;
                  init_done <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            IDLE: begin
               busy <= 1'b0;
               if (start) begin
                  state     <= STREAM;
                  busy      <= 1'b1;
                  dir_inv   <= start_inv;
                  issue_k   <= start_inv ? idx_t'(N_TW - 1) : idx_t'(1);
                  issue_cnt <= idx_t'(N_TW - 1);
               end
            end
            STREAM: begin
               if (pop && tw_last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= INIT;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ntt_twiddle_gen.sv
// Directed bench for ntt_twiddle_gen: table build timing, forward stream with and without
// stalls, ignored starts, mid-stream reset, and the inverse stream when NTT_TW_INV_EN is set.
module tb_ntt_twiddle_gen;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        mode_inv;
   logic [11:0] tw_data;
   logic [6:0]  tw_idx;
   logic        tw_valid;
   logic        tw_ready;
   logic        tw_last;
   logic        busy;
   logic        init_done;

   int checks   = 0;
   int failures = 0;
   int model [128];
   int cap   [128];

   ntt_twiddle_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
`ifdef NTT_TW_INV_EN
      .mode_inv  (mode_inv),
`endif
      .tw_data   (tw_data),
      .tw_idx    (tw_idx),
      .tw_valid  (tw_valid),
      .tw_ready  (tw_ready),
      .tw_last   (tw_last),
      .busy      (busy),
      .init_done (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int bitrev7(input int k);
      int r = 0;
      for (int b = 0; b < 7; b++) begin
         if ((k >> b) & 1) r |= 1 << (6 - b);
      end
      return r;
   endfunction

   function automatic int zeta(input int k);
      int r = 1;
      int e = bitrev7(k);
      for (int j = 0; j < e; j++) r = (r * 17) % 3329;
      return r;
   endfunction

   task automatic do_init(input bit poke);
      rst_n = 1'b1;
      for (int n = 1; n <= 128; n++) begin
         @(posedge clk); #1;
         start = poke && (n == 50);
         if (n < 128) begin
            check("init_done_during_init", init_done, 0);
            check("busy_during_init", busy, 1);
         end else begin
            check("init_done_at_128", init_done, 1);
            check("busy_after_init", busy, 0);
         end
      end
      start = 1'b0;
   endtask

   // Returns after the 127th beat is accepted, or right after asserting reset when abort_k hits
   task automatic run_stream(input bit inv, input bit stall, input int abort_k, input bit poke);
      int   beats = 0;
      int   first_cyc = -1;
      int   last_cyc = -1;
      int   k;
      logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
      logic [11:0] pd = '0;
      logic [6:0]  pi = '0;
      k = inv ? 127 : 1;
      mode_inv = inv;
      start    = 1'b1;
      tw_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      pr       = tw_ready;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (cyc == 1) check("busy_in_stream", busy, 1);
         if (pv && pr) begin
            check("beat_idx", pi, k);
            check("beat_data", pd, model[k]);
            check("beat_last", pl, (beats == 126));
            cap[k] = pd;
            beats++;
            k = inv ? k - 1 : k + 1;
            if (beats == 127) begin
               last_cyc = cyc;
               break;
            end
         end else if (pv && !pr) begin
            check("stall_valid_hold", tw_valid, 1);
            check("stall_data_hold", tw_data, pd);
            check("stall_idx_hold", tw_idx, pi);
            check("stall_last_hold", tw_last, pl);
         end
         if (tw_valid && first_cyc < 0) first_cyc = cyc;
         if (abort_k != 0 && tw_valid && tw_idx == 7'(abort_k)) begin
            rst_n = 1'b0;
            #1;
            check("abort_valid", tw_valid, 0);
            check("abort_data", tw_data, 0);
            check("abort_idx", tw_idx, 0);
            check("abort_last", tw_last, 0);
            check("abort_busy", busy, 0);
            check("abort_init_done", init_done, 0);
            return;
         end
         if (poke && cyc == 10) start = 1'b1;
         pv = tw_valid; pd = tw_data; pi = tw_idx; pl = tw_last;
         tw_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         pr = tw_ready;
      end
      check("beat_count", beats, 127);
      check("first_valid_cycle", first_cyc, 2);
      if (!stall) check("last_accept_cycle", last_cyc, 129);
      check("valid_after_last", tw_valid, 0);
      check("busy_after_last", busy, 0);
      tw_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_no_valid", tw_valid, 0);
   endtask

   initial begin
      for (int k = 0; k < 128; k++) model[k] = zeta(k);
      rst_n = 1'b0; start = 1'b0; mode_inv = 1'b0; tw_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", tw_valid, 0);
      check("rst_data", tw_data, 0);
      check("rst_idx", tw_idx, 0);
      check("rst_last", tw_last, 0);
      check("rst_busy", busy, 0);
      check("rst_init_done", init_done, 0);

      do_init(1'b1);
      repeat (4) begin
         @(posedge clk); #1;
         check("idle_after_init_start", tw_valid, 0);
         check("idle_busy", busy, 0);
      end

      run_stream(1'b0, 1'b0, 0, 1'b1);
      check("zeta_k1", cap[1], 1729);
      check("zeta_k2", cap[2], 2580);
      check("zeta_k3", cap[3], 3289);
      check("zeta_k64", cap[64], 17);
      check("zeta_k127", cap[127], 2154);

      run_stream(1'b0, 1'b1, 0, 1'b1);

      run_stream(1'b0, 1'b0, 40, 1'b0);
      @(posedge clk); #1;
      check("reset_hold_valid", tw_valid, 0);
      do_init(1'b0);
      run_stream(1'b0, 1'b0, 0, 1'b0);
      check("restart_zeta_k1", cap[1], 1729);

`ifdef NTT_TW_INV_EN
      for (int k = 0; k < 128; k++) cap[k] = -1;
      run_stream(1'b1, 1'b1, 0, 1'b0);
      check("inv_zeta_k127", cap[127], 2154);
      check("inv_zeta_k1", cap[1], 1729);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
